// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings,
// counter sizing and the address-error helper used by the responder
// and by the CPU stall logic.
package dmem_responder_pkg;

  localparam int DATA_W      = 32;
  localparam int CNT_W       = 4;
  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A byte address is in error when it is not word aligned or when any
  // bit above the word-index field is set.
  function automatic logic addr_err(input logic [31:0] adr, input int addr_w);
    logic [31:0] upper;
    upper = adr >> (addr_w + 2);
    return (adr[1:0] != 2'b00) || (upper != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous write, combinational read,
// one shared index for both.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: one word per clock when enabled.
  // NOTE: the storage has no reset on purpose; clearing a RAM costs a
  // cycle per word and its contents are defined by software, not by reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[widx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for CPU loads and stores. A request is captured
// when req_valid meets req_ready in IDLE, waits LATENCY cycles, commits
// to the array on the edge that enters RESP, and is held there until the
// CPU takes the response with rsp_ready.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_adr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_we;
  logic              cap_err;
  logic [ADDR_W-1:0] cap_widx;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic              commit;
  logic              arr_we;

  // The commit edge is the one that moves BUSY -> RESP.
  assign commit = (state == ST_BUSY) && (cnt == '0);

  // A store reaches the array only if it is clean and no reset lands on
  // the commit edge, so a reset before RESP drops the store.
  assign arr_we = commit && cap_we && !cap_err && !rst;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .widx  (cap_widx),
    .wdata (cap_wdata),
    .rdata (arr_rdata)
  );

  // Handshake FSM with latency counter, request capture and registered
  // outputs. Every accept passes through BUSY, so rsp_valid rises exactly
  // LATENCY edges after the accept edge for any LATENCY in 1..15.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the order of statements cannot matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_err   <= 1'b0;
      cap_widx  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone accepts.
          if (req_valid) begin
            cap_we    <= req_we;
            cap_err   <= addr_err(req_adr, ADDR_W);
            cap_widx  <= req_adr[ADDR_W+1:2];
            cap_wdata <= req_wdata;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= cap_err;
            rsp_rdata <= (cap_we || cap_err) ? '0 : arr_rdata;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=3 instance for the main
// scenarios and a LATENCY=1 instance for the short-latency issue pattern.
// Outputs are sampled on the falling edge; inputs change there as well.
module tb_dmem_responder;

  logic clk;
  logic rst;

  // LATENCY=3 instance
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  // LATENCY=1 instance
  logic        l1_req_valid, l1_req_ready, l1_req_we;
  logic [31:0] l1_req_adr, l1_req_wdata;
  logic        l1_rsp_valid, l1_rsp_ready, l1_rsp_err;
  logic [31:0] l1_rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.ADDR_W(8), .LATENCY(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut_l1 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (l1_req_valid),
    .req_ready (l1_req_ready),
    .req_we    (l1_req_we),
    .req_adr   (l1_req_adr),
    .req_wdata (l1_req_wdata),
    .rsp_valid (l1_rsp_valid),
    .rsp_ready (l1_rsp_ready),
    .rsp_rdata (l1_rsp_rdata),
    .rsp_err   (l1_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request to the LATENCY=3 instance and wait until rsp_valid.
  // After the accept edge the request inputs are scrambled so a design that
  // keeps sampling them would be caught. Leaves the DUT sitting in RESP.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    req_we    = we;
    req_adr   = adr;
    req_wdata = wdata;
    req_valid = 1'b1;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_adr   = 32'hFFFF_FFFF;
    req_wdata = ~wdata;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  // Take the response; on return the DUT has left RESP.
  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    issue(we, adr, wdata, rd, er, lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_rdata"}, rd, exp_rdata);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    release_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_adr      = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b0;
    l1_req_valid = 1'b0;
    l1_req_we    = 1'b0;
    l1_req_adr   = '0;
    l1_req_wdata = '0;
    l1_rsp_ready = 1'b1;

    // 1. Reset for two cycles, then idle state on both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_l1_req_ready", {31'd0, l1_req_ready}, 32'd1);
    check("rst_l1_rsp_valid", {31'd0, l1_rsp_valid}, 32'd0);

    // 2. Store then load the same word; a store responds with rdata=0.
    xact("st_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
    xact("ld_10", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xact("st_00", 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0);
    xact("st_fc", 1'b1, 32'h0000_03FC, 32'h5A5A_0FF0, 32'h0, 1'b0);
    xact("ld_fc", 1'b0, 32'h0000_03FC, 32'h0, 32'h5A5A_0FF0, 1'b0);

    // 3. Misaligned load, out-of-range store aliasing word 0.
    xact("ld_13_mis", 1'b0, 32'h0000_0013, 32'h0, 32'h0, 1'b1);
    check("err_cleared", {31'd0, rsp_err}, 32'd0);
    xact("st_400_oor", 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xact("ld_00_kept", 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 1'b0);
    xact("ld_hi_oor", 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b1);

    // 4. Hold the response for five cycles with a stray request pulse.
    issue(1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
    check("hold_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_adr   = 32'h0000_0010;
        req_wdata = 32'h0000_0000;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    release_rsp();
    xact("ld_10_after_hold", 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // 5. Reset during BUSY drops the store; reset in RESP keeps it.
    xact("st_20", 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_adr   = 32'h0000_0020;
    req_wdata = 32'h0BAD_BAD0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_busy_quiet", {31'd0, rsp_valid}, 32'd0);
    xact("ld_20_prior", 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0);

    issue(1'b1, 32'h0000_0024, 32'h1234_5678, rd, er, lat);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_resp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    xact("ld_24_kept", 1'b0, 32'h0000_0024, 32'h0, 32'h1234_5678, 1'b0);

    // 6. LATENCY=1 instance with rsp_ready tied high and req_valid held.
    // Expected per falling edge: accept, RESP, IDLE, accept, RESP, IDLE,
    // i.e. one IDLE cycle between transactions.
    @(negedge clk);
    l1_req_valid = 1'b1;
    l1_req_we    = 1'b1;
    l1_req_adr   = 32'h0000_0010;
    l1_req_wdata = 32'hA5A5_A5A5;
    check("l1_ready_a", {31'd0, l1_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("l1_a_busy_valid", {31'd0, l1_rsp_valid}, 32'd0);
    check("l1_a_busy_ready", {31'd0, l1_req_ready}, 32'd0);
    l1_req_we    = 1'b0;
    l1_req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    check("l1_a_rsp_valid", {31'd0, l1_rsp_valid}, 32'd1);
    check("l1_a_rsp_rdata", l1_rsp_rdata, 32'h0);
    check("l1_a_rsp_err", {31'd0, l1_rsp_err}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("l1_idle_valid", {31'd0, l1_rsp_valid}, 32'd0);
    check("l1_idle_ready", {31'd0, l1_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    l1_req_valid = 1'b0;
    check("l1_b_busy_ready", {31'd0, l1_req_ready}, 32'd0);
    check("l1_b_busy_valid", {31'd0, l1_rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("l1_b_rsp_valid", {31'd0, l1_rsp_valid}, 32'd1);
    check("l1_b_rsp_rdata", l1_rsp_rdata, 32'hA5A5_A5A5);
    @(posedge clk);
    @(negedge clk);
    check("l1_end_ready", {31'd0, l1_req_ready}, 32'd1);
    check("l1_end_rdata", l1_rsp_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
